// File: rtl/preact_mac_pkg.sv
// ============================================================================
// Module      : preact_mac_pkg
// Description : Q6.9 fixed-point constants and the shared round/saturate helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package preact_mac_pkg;

  localparam int          FRAC  = 9;
  localparam logic [15:0] Q_MAX = 16'h7FFF;
  localparam logic [15:0] Q_MIN = 16'h8000;
  localparam logic [15:0] Q_ONE = 16'h0200;

  // Wide working width; callers sign-extend their accumulator into it.
  localparam int RS_W = 64;

  typedef struct packed {
    logic        sat;
    logic [15:0] x;
  } q_result_t;

  // Round half toward +inf at bit position frac, then clip to Q6.9.
  function automatic q_result_t round_sat(input logic signed [RS_W-1:0] v,
                                          input int unsigned            frac);
    logic signed [RS_W-1:0] t;
    logic signed [RS_W-1:0] r;
    q_result_t              res;
    t = v + (RS_W'(1) << (frac - 1));
    r = t >>> frac;
    if (r > 64'sd32767) begin
      res.sat = 1'b1;
      res.x   = Q_MAX;
    end else if (r < -64'sd32768) begin
      res.sat = 1'b1;
      res.x   = Q_MIN;
    end else begin
      res.sat = 1'b0;
      res.x   = r[15:0];
    end
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/preact_mac_if.sv
// ============================================================================
// Module      : preact_mac_if
// Description : Element input stream and result output stream of preact_mac.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface preact_mac_if #(
  parameter int DATA_W = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_w;
  logic [DATA_W-1:0] in_bias;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_x;
  logic              out_sat;

  modport master (
    output in_valid, in_a, in_w, in_bias, in_last, out_ready,
    input  in_ready, out_valid, out_x, out_sat
  );

  modport slave (
    input  in_valid, in_a, in_w, in_bias, in_last, out_ready,
    output in_ready, out_valid, out_x, out_sat
  );
endinterface

`default_nettype wire

// File: rtl/preact_mac.sv
// ============================================================================
// Module      : preact_mac
// Description : Streaming Q6.9 dot product plus bias, rounded and saturated
//               to the tanh stage pre-activation.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module preact_mac #(
  parameter int DATA_W = 16,
  parameter int FRAC   = 9,
  parameter int ACC_W  = 40
) (
  input  wire logic   clk,
  input  wire logic   rst_n,
  preact_mac_if.slave bus
);
  import preact_mac_pkg::*;

  localparam int P_W = 2 * DATA_W;

  logic signed [P_W-1:0]    r_p;
  logic                     r_p_vld;
  logic                     r_p_last;
  logic        [DATA_W-1:0] r_bias;
  logic                     r_first;
  logic signed [ACC_W-1:0]  r_acc;
  logic                     r_acc_first;
  logic                     r_out_valid;
  logic        [DATA_W-1:0] r_out_x;
  logic                     r_out_sat;

  logic                     w_hold;
  logic signed [P_W-1:0]    w_a_ext;
  logic signed [P_W-1:0]    w_w_ext;
  logic signed [P_W-1:0]    w_prod;
  logic signed [ACC_W-1:0]  w_sum;
  logic signed [ACC_W-1:0]  w_bias_q18;
  logic signed [ACC_W-1:0]  w_biased;
  q_result_t                w_res;

  assign w_hold = r_out_valid && !bus.out_ready;

  assign w_a_ext = {{DATA_W{bus.in_a[DATA_W-1]}}, bus.in_a};
  assign w_w_ext = {{DATA_W{bus.in_w[DATA_W-1]}}, bus.in_w};
  assign w_prod  = w_a_ext * w_w_ext;

  assign w_sum      = (r_acc_first ? '0 : r_acc) + {{(ACC_W-P_W){r_p[P_W-1]}}, r_p};
  // Bias is Q6.9; align it to the Q.18 accumulator scale before adding.
  assign w_bias_q18 = {{(ACC_W-DATA_W){r_bias[DATA_W-1]}}, r_bias} <<< FRAC;
  assign w_biased   = w_sum + w_bias_q18;
  assign w_res      = round_sat({{(RS_W-ACC_W){w_biased[ACC_W-1]}}, w_biased},
                                FRAC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p         <= '0;
      r_p_vld     <= 1'b0;
      r_p_last    <= 1'b0;
      r_bias      <= '0;
      r_first     <= 1'b1;
      r_acc       <= '0;
      r_acc_first <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_x     <= '0;
      r_out_sat   <= 1'b0;
    end else if (!w_hold) begin
      // Without hold a valid output is necessarily being consumed this edge.
      if (r_out_valid) begin
        r_out_valid <= 1'b0;
      end

      if (bus.in_valid) begin
        r_p      <= w_prod;
        r_p_vld  <= 1'b1;
        r_p_last <= bus.in_last;
        if (r_first) begin
          r_bias <= bus.in_bias;
        end
        r_first  <= bus.in_last;
      end else begin
        r_p_vld  <= 1'b0;
      end

      if (r_p_vld) begin
        if (r_p_last) begin
          r_out_x     <= w_res.x;
          r_out_sat   <= w_res.sat;
          r_out_valid <= 1'b1;
          r_acc_first <= 1'b1;
        end else begin
          r_acc       <= w_sum;
          r_acc_first <= 1'b0;
        end
      end
    end
  end

  assign bus.in_ready  = !w_hold;
  assign bus.out_valid = r_out_valid;
  assign bus.out_x     = r_out_x;
  assign bus.out_sat   = r_out_sat;

endmodule

`default_nettype wire

// File: tb/tb_preact_mac.sv
// ============================================================================
// Module      : tb_preact_mac
// Description : Self-checking bench for preact_mac with a dot-product model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_preact_mac;

  logic clk;
  logic rst_n;

  preact_mac_if #(.DATA_W(16)) bus ();

  preact_mac #(.DATA_W(16), .FRAC(9), .ACC_W(40)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] got_x[$];
  logic        got_s[$];
  logic [15:0] va[$];
  logic [15:0] vw[$];
  logic [15:0] vb;

  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      got_x.push_back(bus.out_x);
      got_s.push_back(bus.out_sat);
    end
  end

  // Reference: exact dot product, bias, round-to-nearest ties up, clip.
  function automatic void model(output logic [15:0] x, output logic s);
    longint acc = 0;
    longint n;
    longint q;
    for (int i = 0; i < va.size(); i++)
      acc += longint'($signed(va[i])) * longint'($signed(vw[i]));
    acc += longint'($signed(vb)) * 512;
    n = acc + 256;
    q = n / 512;
    if ((n % 512) != 0 && n < 0) q = q - 1;
    if (q > 32767) begin
      x = 16'h7FFF; s = 1'b1;
    end else if (q < -32768) begin
      x = 16'h8000; s = 1'b1;
    end else begin
      x = 16'(q); s = 1'b0;
    end
  endfunction

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic drive_elem(input logic [15:0] a, input logic [15:0] w,
                            input logic [15:0] b, input logic last,
                            output bit ok);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_w     = w;
    bus.in_bias  = b;
    bus.in_last  = last;
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic send_vec(output bit ok);
    bit acc;
    ok = 1'b1;
    for (int i = 0; i < va.size(); i++) begin
      drive_elem(va[i], vw[i], (i == 0) ? vb : 16'($urandom),
                 (i == va.size() - 1), acc);
      if (!acc) begin
        ok = 1'b0;
        break;
      end
    end
  endtask

  task automatic wait_out(input int n);
    for (int i = 0; i < 400 && got_x.size() < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_got();
    got_x.delete();
    got_s.delete();
  endtask

  task automatic test_reset();
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid);
    end
    n_cmp++;
    if (bus.out_x !== 16'h0000) begin
      n_err++; $display("FAIL reset_out_x: got %h expected 0000", bus.out_x);
    end
    n_cmp++;
    if (bus.out_sat !== 1'b0) begin
      n_err++; $display("FAIL reset_out_sat: got %b expected 0", bus.out_sat);
    end
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready);
    end
  endtask

  task automatic test_single();
    bit ok;
    clear_got();
    bus.out_ready = 1'b1;
    drive_elem(16'h0200, 16'h0200, 16'h0100, 1'b1, ok);
    n_cmp++;
    if (!ok) begin
      n_err++; $display("FAIL single_accept: got timeout expected accept");
    end
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin
      n_err++; $display("FAIL single_latency_early: got out_valid %b expected 0", bus.out_valid);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (bus.out_valid !== 1'b1 || bus.out_x !== 16'h0300 || bus.out_sat !== 1'b0) begin
      n_err++;
      $display("FAIL single_result: got v=%b x=%h s=%b expected v=1 x=0300 s=0",
               bus.out_valid, bus.out_x, bus.out_sat);
    end
    wait_out(1);
    clear_got();
  endtask

  task automatic test_four();
    bit ok;
    clear_got();
    va = '{16'h0100, 16'h0100, 16'h0100, 16'h0100};
    vw = '{16'h0400, 16'h0400, 16'h0400, 16'h0400};
    vb = 16'hFF00;
    send_vec(ok);
    wait_out(1);
    n_cmp++;
    if (!ok || got_x.size() != 1 || got_x[0] !== 16'h0700 || got_s[0] !== 1'b0) begin
      n_err++;
      $display("FAIL four_elem: got n=%0d x=%h expected n=1 x=0700 s=0",
               got_x.size(), (got_x.size() > 0) ? got_x[0] : 16'hxxxx);
    end
  endtask

  task automatic test_saturation();
    bit ok;
    logic [15:0] sa[2] = '{16'h7FFF, 16'h8000};
    logic [15:0] se[2] = '{16'h7FFF, 16'h8000};
    for (int c = 0; c < 2; c++) begin
      clear_got();
      va.delete();
      vw.delete();
      for (int i = 0; i < 8; i++) begin
        va.push_back(sa[c]);
        vw.push_back(16'h7FFF);
      end
      vb = 16'h0000;
      send_vec(ok);
      wait_out(1);
      n_cmp++;
      if (!ok || got_x.size() != 1 || got_x[0] !== se[c] || got_s[0] !== 1'b1) begin
        n_err++;
        $display("FAIL saturation_%0d: got n=%0d x=%h expected x=%h s=1", c,
                 got_x.size(), (got_x.size() > 0) ? got_x[0] : 16'hxxxx, se[c]);
      end
    end
  endtask

  task automatic test_rounding();
    bit ok;
    logic [15:0] ta[4] = '{16'h0001, 16'h0001, 16'hFFFF, 16'hFFFF};
    logic [15:0] tw[4] = '{16'h0100, 16'h00FF, 16'h0100, 16'h0101};
    logic [15:0] te[4] = '{16'h0001, 16'h0000, 16'h0000, 16'hFFFF};
    for (int c = 0; c < 4; c++) begin
      clear_got();
      va = '{ta[c]};
      vw = '{tw[c]};
      vb = 16'h0000;
      send_vec(ok);
      wait_out(1);
      n_cmp++;
      if (!ok || got_x.size() != 1 || got_x[0] !== te[c] || got_s[0] !== 1'b0) begin
        n_err++;
        $display("FAIL rounding_%0d: got n=%0d x=%h expected x=%h s=0", c,
                 got_x.size(), (got_x.size() > 0) ? got_x[0] : 16'hxxxx, te[c]);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit ok1;
    bit ok2;
    logic [15:0] ex;
    logic        es;
    time t0;
    clear_got();
    bus.out_ready = 1'b1;
    t0 = $time;
    va = '{16'h0100, 16'h0100, 16'h0100, 16'h0100};
    vw = '{16'h0400, 16'h0400, 16'h0400, 16'h0400};
    vb = 16'hFF00;
    send_vec(ok1);
    va = '{16'hF123, 16'h0456};
    vw = '{16'h0321, 16'hFE00};
    vb = 16'h0040;
    model(ex, es);
    send_vec(ok2);
    n_cmp++;
    if (!ok1 || !ok2 || ($time - t0) != 60) begin
      n_err++;
      $display("FAIL back_to_back_rate: got %0t for 6 elements expected 60", $time - t0);
    end
    wait_out(2);
    n_cmp++;
    if (got_x.size() != 2 || got_x[0] !== 16'h0700 || got_x[1] !== ex || got_s[1] !== es) begin
      n_err++;
      $display("FAIL back_to_back_results: got n=%0d x1=%h expected x0=0700 x1=%h",
               got_x.size(), (got_x.size() > 1) ? got_x[1] : 16'hxxxx, ex);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int bad = 0;
    clear_got();
    bus.out_ready = 1'b0;
    va = '{16'h0200}; vw = '{16'h0200}; vb = 16'h0100;
    send_vec(ok);
    va = '{16'h0400}; vw = '{16'h0400}; vb = 16'h0000;
    send_vec(ok);
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (bus.out_valid !== 1'b1 || bus.out_x !== 16'h0300 || bus.in_ready !== 1'b0) begin
        n_err++;
        $display("FAIL backpressure_hold_%0d: got v=%b x=%h rdy=%b expected v=1 x=0300 rdy=0",
                 i, bus.out_valid, bus.out_x, bus.in_ready);
      end
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    wait_out(2);
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (!ok || got_x.size() != 2) bad = 1;
    else if (got_x[0] !== 16'h0300 || got_x[1] !== 16'h0800) bad = 1;
    if (bad != 0) begin
      n_err++;
      $display("FAIL backpressure_drain: got n=%0d x0=%h x1=%h expected n=2 0300 0800",
               got_x.size(), (got_x.size() > 0) ? got_x[0] : 16'hxxxx,
               (got_x.size() > 1) ? got_x[1] : 16'hxxxx);
    end
  endtask

  task automatic test_random();
    logic [15:0] exp_x[$];
    logic        exp_s[$];
    logic [15:0] ex;
    logic        es;
    bit          drv_done = 1'b0;
    int          n_to = 0;
    clear_got();
    bus.out_ready = 1'b1;
    fork
      begin
        bit ok;
        for (int v = 0; v < 40; v++) begin
          int len = $urandom_range(1, 8);
          bit full = ($urandom_range(0, 1) == 1);
          va.delete();
          vw.delete();
          for (int i = 0; i < len; i++) begin
            if (full) begin
              va.push_back(16'($urandom));
              vw.push_back(16'($urandom));
            end else begin
              va.push_back(16'($urandom_range(0, 2047)) - 16'd1024);
              vw.push_back(16'($urandom_range(0, 2047)) - 16'd1024);
            end
          end
          vb = 16'($urandom);
          model(ex, es);
          exp_x.push_back(ex);
          exp_s.push_back(es);
          send_vec(ok);
          if (!ok) n_to++;
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
        end
        drv_done = 1'b1;
      end
      begin
        while (!drv_done) begin
          @(posedge clk);
          #1;
          bus.out_ready = ($urandom_range(0, 9) < 7);
        end
      end
    join
    bus.out_ready = 1'b1;
    wait_out(exp_x.size());
    n_cmp++;
    if (n_to != 0 || got_x.size() != exp_x.size()) begin
      n_err++;
      $display("FAIL random_count: got %0d results (%0d stalls) expected %0d",
               got_x.size(), n_to, exp_x.size());
    end else begin
      for (int i = 0; i < exp_x.size(); i++) begin
        n_cmp++;
        if (got_x[i] !== exp_x[i] || got_s[i] !== exp_s[i]) begin
          n_err++;
          $display("FAIL random_vec_%0d: got x=%h s=%b expected x=%h s=%b",
                   i, got_x[i], got_s[i], exp_x[i], exp_s[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit acc1;
    bit acc2;
    // A held result plus a partially loaded vector are wiped asynchronously.
    clear_got();
    bus.out_ready = 1'b0;
    va = '{16'h0200}; vw = '{16'h0200}; vb = 16'h0100;
    send_vec(ok);
    drive_elem(16'h7FFF, 16'h7FFF, 16'h1234, 1'b0, acc1);
    n_cmp++;
    if (!ok || !acc1 || bus.out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL reset_mid_setup: got out_valid=%b expected 1", bus.out_valid);
    end
    #3;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.out_x !== 16'h0000 || bus.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_mid_async: got v=%b x=%h rdy=%b expected v=0 x=0000 rdy=1",
               bus.out_valid, bus.out_x, bus.in_ready);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    // Two of four elements accumulate, then reset discards them.
    bus.out_ready = 1'b1;
    drive_elem(16'h7FFF, 16'h7FFF, 16'h2345, 1'b0, acc1);
    drive_elem(16'h7FFF, 16'h7FFF, 16'h0000, 1'b0, acc2);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_got();
    va = '{16'h0200}; vw = '{16'h0200}; vb = 16'h0000;
    send_vec(ok);
    wait_out(1);
    n_cmp++;
    if (!acc1 || !acc2 || !ok || got_x.size() != 1 || got_x[0] !== 16'h0200 || got_s[0] !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid_after: got n=%0d x=%h expected n=1 x=0200 s=0",
               got_x.size(), (got_x.size() > 0) ? got_x[0] : 16'hxxxx);
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_w      = '0;
    bus.in_bias   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    #2;
    test_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    test_single();
    test_four();
    test_saturation();
    test_rounding();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no completion expected finish before 400000");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
